// File: rtl/legv8_inst_encoder_if.sv
// Handshake bundle between the instruction-field producer, the encoder and
// the instruction-memory loader that consumes the packed words.
interface legv8_inst_encoder_if #(
  parameter int ADDR_W = 10
);
  // Input side: decoded fields offered to the encoder
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic              op_sel;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [63:0]       imm;
  // Output side: packed word and its byte address
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instruction;
  logic [ADDR_W+1:0] out_addr;

  modport slave (
    input  in_valid, fmt, op_sel, rd, rn, imm, out_ready,
    output in_ready, out_valid, instruction, out_addr
  );

  modport master (
    output in_valid, fmt, op_sel, rd, rn, imm, out_ready,
    input  in_ready, out_valid, instruction, out_addr
  );
endinterface

// File: rtl/legv8_inst_encoder.sv
// LEGv8 instruction encoder: packs D / CB / I / B fields plus a 64-bit
// immediate into a 32-bit word. Two-stage valid/ready pipeline: S1 holds the
// raw fields and range-checks the immediate, S2 holds the encoded word and
// its byte address. Out-of-range entries are dropped from S1 without
// waiting for S2 space and counted.
module legv8_inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  legv8_inst_encoder_if.slave  bus,
  output logic                 range_err,
  output logic [7:0]           err_count
);

  localparam logic [1:0] FMT_D  = 2'd0;
  localparam logic [1:0] FMT_CB = 2'd1;
  localparam logic [1:0] FMT_I  = 2'd2;

  // Stage 1 holding registers
  logic        s1_valid;
  logic [1:0]  s1_fmt;
  logic        s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rn;
  logic [63:0] s1_imm;

  logic              s1_in_range;
  logic              s1_err;
  logic              s1_adv;
  logic              in_fire;
  logic              out_fire;
  logic [31:0]       enc_word;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;

  // Immediate range check: the bits above the field must be a pure sign
  // extension (signed formats) or zero (ADDI's unsigned immediate)
  always_comb begin
    case (s1_fmt)
      FMT_D:   s1_in_range = (&s1_imm[63:8])  || !(|s1_imm[63:8]);
      FMT_CB:  s1_in_range = (&s1_imm[63:18]) || !(|s1_imm[63:18]);
      FMT_I:   s1_in_range = !(|s1_imm[63:12]);
      default: s1_in_range = (&s1_imm[63:25]) || !(|s1_imm[63:25]);
    endcase
  end

  // Field packing for each format
  always_comb begin
    case (s1_fmt)
      FMT_D:   enc_word = {(s1_op ? 11'b11111000010 : 11'b11111000000),
                           s1_imm[8:0], 2'b00, s1_rn, s1_rd};
      FMT_CB:  enc_word = {(s1_op ? 8'b10110101 : 8'b10110100),
                           s1_imm[18:0], s1_rd};
      FMT_I:   enc_word = {10'b1001000100, s1_imm[11:0], s1_rn, s1_rd};
      default: enc_word = {6'b000101, s1_imm[25:0]};
    endcase
  end

  // A bad entry leaves S1 regardless of S2 occupancy, so it never stalls input
  assign s1_err   = s1_valid && !s1_in_range;
  assign s1_adv   = s1_valid && (!bus.out_valid || bus.out_ready || s1_err);
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  // The next word's address already accounts for a same-cycle transfer
  assign idx_next = out_fire ? idx + {{(ADDR_W-1){1'b0}}, 1'b1} : idx;

  // Stage 1: capture fields on an input handshake, empty on advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= 2'd0;
      s1_op    <= 1'b0;
      s1_rd    <= 5'd0;
      s1_rn    <= 5'd0;
      s1_imm   <= 64'd0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_fmt   <= bus.fmt;
      s1_op    <= bus.op_sel;
      s1_rd    <= bus.rd;
      s1_rn    <= bus.rn;
      s1_imm   <= bus.imm;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: encoded word, byte address and the word-index counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid   <= 1'b0;
      bus.instruction <= 32'd0;
      bus.out_addr    <= '0;
      idx             <= '0;
    end else if (clear) begin
      bus.out_valid   <= 1'b0;
      bus.instruction <= 32'd0;
      bus.out_addr    <= '0;
      idx             <= '0;
    end else begin
      idx <= idx_next;
      if (s1_adv && !s1_err) begin
        bus.out_valid   <= 1'b1;
        bus.instruction <= enc_word;
        bus.out_addr    <= {idx_next, 2'b00};
      end else if (out_fire) begin
        bus.out_valid   <= 1'b0;
      end
    end
  end

  // Drop reporting: one-cycle pulse and a saturating count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_err <= 1'b0;
      err_count <= 8'd0;
    end else if (clear) begin
      range_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      range_err <= s1_adv && s1_err;
      if (s1_adv && s1_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_legv8_inst_encoder.sv
// Testbench for legv8_inst_encoder: directed scenarios followed by random
// traffic, all outputs scored against a field-level reference model.
module tb_legv8_inst_encoder;
  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       range_err;
  logic [7:0] err_count;

  legv8_inst_encoder_if #(.ADDR_W(AW)) bus ();

  legv8_inst_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .bus       (bus.slave),
    .range_err (range_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_in_range(input logic [1:0] f, input longint v);
    case (f)
      2'd0:    return (v >= -256) && (v <= 255);
      2'd1:    return (v >= -262144) && (v <= 262143);
      2'd2:    return (v >= 0) && (v <= 4095);
      default: return (v >= -33554432) && (v <= 33554431);
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [1:0] f, input logic op,
                                             input logic [4:0] rd, input logic [4:0] rn,
                                             input longint v);
    longint unsigned u;
    longint unsigned w;
    longint unsigned d;
    longint unsigned n;
    u = v;
    d = 64'(rd);
    n = 64'(rn);
    case (f)
      2'd0:    w = (op ? 64'd1986 : 64'd1984) * 64'd2097152 + (u % 64'd512) * 64'd4096 + n * 64'd32 + d;
      2'd1:    w = (op ? 64'd181 : 64'd180) * 64'd16777216 + (u % 64'd524288) * 64'd32 + d;
      2'd2:    w = 64'd580 * 64'd4194304 + (u % 64'd4096) * 64'd1024 + n * 64'd32 + d;
      default: w = 64'd5 * 64'd67108864 + (u % 64'd67108864);
    endcase
    return w[31:0];
  endfunction

  function automatic longint gen_imm(input logic [1:0] f);
    longint lo;
    longint hi;
    int     s;
    s = $urandom_range(0, 6);
    case (f)
      2'd0:    begin lo = -256;      hi = 255;      end
      2'd1:    begin lo = -262144;   hi = 262143;   end
      2'd2:    begin lo = 0;         hi = 4095;     end
      default: begin lo = -33554432; hi = 33554431; end
    endcase
    case (s)
      0:       return longint'({$urandom(), $urandom()});
      1:       return lo;
      2:       return hi;
      3:       return hi + 1;
      4:       return lo - 1;
      default: return lo + longint'($urandom_range(0, int'(hi - lo)));
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          model_idx  = 0;
  int          model_errs = 0;
  bit          pend1 = 0;
  bit          pend2 = 0;

  task automatic model_flush();
    exp_q.delete();
    model_idx  = 0;
    model_errs = 0;
    pend1 = 0;
    pend2 = 0;
  endtask

  // Per-cycle scoring of transfers, drop pulses and the error count
  always @(negedge clk) begin
    if (!reset_n) begin
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_range_err", range_err, 0);
      model_flush();
    end else begin
      bit bad_hs;
      check_eq("range_err", range_err, pend2);
      if (pend2 && model_errs < 255) model_errs++;
      check_eq("err_count", err_count, model_errs);
      if (clear) begin
        model_flush();
      end else begin
        bad_hs = 0;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_word", bus.out_valid, 0);
          end else begin
            logic [31:0] w;
            w = exp_q.pop_front();
            check_eq("instruction", bus.instruction, w);
            check_eq("out_addr", bus.out_addr, model_idx * 4);
            $display("word %08h @ %0d", bus.instruction, bus.out_addr);
            model_idx = (model_idx + 1) % (1 << AW);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          if (model_in_range(bus.fmt, longint'(bus.imm)))
            exp_q.push_back(model_word(bus.fmt, bus.op_sel, bus.rd, bus.rn, longint'(bus.imm)));
          else
            bad_hs = 1;
        end
        pend2 = pend1;
        pend1 = bad_hs;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [1:0] f, input logic op, input logic [4:0] rd,
                      input logic [4:0] rn, input longint v);
    bit ok;
    bus.fmt      = f;
    bus.op_sel   = op;
    bus.rd       = rd;
    bus.rn       = rn;
    bus.imm      = v;
    bus.in_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) check_eq("push_accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pend1 && !pend2 && !bus.out_valid) break;
    end
    check_eq("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n       = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fmt       = 2'd0;
    bus.op_sel    = 1'b0;
    bus.rd        = 5'd0;
    bus.rn        = 5'd0;
    bus.imm       = 64'd0;
    #1;
    check_eq("reset_instruction", bus.instruction, 0);
    check_eq("reset_out_addr", bus.out_addr, 0);
    check_eq("reset_err_count", err_count, 0);
    check_eq("reset_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // LDUR X1, [X2, #-8] and two-cycle latency
    bus.out_ready = 1'b1;
    push(2'd0, 1'b1, 5'd1, 5'd2, -8);
    @(negedge clk);
    check_eq("latency_cycle1", bus.out_valid, 0);
    @(negedge clk);
    check_eq("latency_cycle2", bus.out_valid, 1);
    check_eq("ldur_word", bus.instruction, 32'hF85F8041);
    check_eq("ldur_addr", bus.out_addr, 0);
    @(posedge clk);
    #1;

    // CBNZ then B
    push(2'd1, 1'b1, 5'd3, 5'd0, -1);
    push(2'd3, 1'b0, 5'd0, 5'd0, -2);
    drain();

    // ADDI upper bound, then an out-of-range immediate, then a normal word
    pulse_clear();
    push(2'd2, 1'b0, 5'd9, 5'd9, 4095);
    push(2'd2, 1'b0, 5'd9, 5'd9, 4096);
    push(2'd2, 1'b0, 5'd4, 5'd5, 7);
    drain();
    check_eq("addi_err_count", err_count, 1);

    // Backpressure: two entries fill the pipe, the third waits
    pulse_clear();
    bus.out_ready = 1'b0;
    push(2'd3, 1'b0, 5'd0, 5'd0, 100);
    push(2'd3, 1'b0, 5'd0, 5'd0, 200);
    bus.in_valid = 1'b1;
    bus.imm      = 64'd300;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    push(2'd3, 1'b0, 5'd0, 5'd0, 300);
    drain();

    // Address wrap with a 2-bit index
    pulse_clear();
    for (int i = 0; i < 5; i++) push(2'd3, 1'b0, 5'd0, 5'd0, longint'(i));
    drain();

    // Clear while a word sits in S2
    bus.out_ready = 1'b0;
    push(2'd2, 1'b0, 5'd1, 5'd1, 1);
    repeat (2) @(negedge clk);
    pulse_clear();
    @(negedge clk);
    check_eq("clear_out_valid", bus.out_valid, 0);
    check_eq("clear_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    push(2'd2, 1'b0, 5'd2, 5'd2, 2);
    repeat (2) @(negedge clk);
    check_eq("after_clear_valid", bus.out_valid, 1);
    check_eq("after_clear_addr", bus.out_addr, 0);
    drain();

    // Reset with both stages occupied
    bus.out_ready = 1'b0;
    push(2'd0, 1'b0, 5'd3, 5'd4, 16);
    push(2'd0, 1'b1, 5'd5, 5'd6, -16);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_instruction", bus.instruction, 0);
    check_eq("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    push(2'd1, 1'b0, 5'd7, 5'd0, 12);
    repeat (2) @(negedge clk);
    check_eq("post_rst_valid", bus.out_valid, 1);
    check_eq("post_rst_addr", bus.out_addr, 0);
    drain();

    // Random traffic with random backpressure and occasional clears
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit acc;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      clear         = ($urandom_range(0, 99) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (clear) begin
        bus.in_valid = 1'b0;
      end else if (acc || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.fmt      = 2'($urandom_range(0, 3));
        bus.op_sel   = 1'($urandom_range(0, 1));
        bus.rd       = 5'($urandom_range(0, 31));
        bus.rn       = 5'($urandom_range(0, 31));
        bus.imm      = gen_imm(bus.fmt);
      end
    end
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/legv8_inst_encoder.md
Name: legv8_inst_encoder

Overview:
- Packs decoded LEGv8 instruction fields and a 64-bit signed immediate into a 32-bit instruction word. It is the inverse of the immediate sign-extension path, for the D (LDUR/STUR), CB (CBZ/CBNZ), I (ADDI) and B formats.
- Feeds the instruction-memory loader. It is a 2-stage valid/ready pipeline with an immediate range check and a byte-address write counter.

Parameters:
- ADDR_W, 10, word-index width of the instruction-memory write address; out_addr is ADDR_W+2 bits wide.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush; drops pipeline contents and zeroes the address counter and the error count
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept input
- fmt  input  2  format select: 0 = D, 1 = CB, 2 = I, 3 = B
- op_sel  input  1  D: 1 = LDUR, 0 = STUR; CB: 1 = CBNZ, 0 = CBZ; ignored for I and B
- rd  input  5  Rt (D, CB) or Rd (I)
- rn  input  5  Rn (D, I)
- imm  input  64  two's-complement immediate: D = byte offset, CB/B = word offset, I = unsigned value
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts the word
- instruction  output  32  encoded word
- out_addr  output  ADDR_W+2  byte address for the word; bits [1:0] are always 00
- range_err  output  1  one-cycle pulse when an entry is dropped for being out of range
- err_count  output  8  saturating count of dropped entries

Behaviour:
- Reset (reset_n low, asynchronous): both stage-valid bits are 0, out_valid = 0, instruction = 0, out_addr = 0, range_err = 0, err_count = 0.
- Stage 1 (S1) capture:
  - A handshake occurs when in_valid and in_ready are both high.
  - in_ready = !s1_valid || s1_adv.
  - s1_adv = s1_valid && (!out_valid || out_ready || s1_err).
- Range check, combinational on S1; an entry is in range when:
  - D: imm[63:8] is all zeros or all ones (fits signed 9 bits).
  - CB: imm[63:18] is uniform (fits signed 19 bits).
  - B: imm[63:25] is uniform (fits signed 26 bits).
  - I: imm[63:12] == 0 (unsigned 0..4095).
- Encoding:
  - D: {op_sel ? 11'b11111000010 : 11'b11111000000, imm[8:0], 2'b00, rn, rd}.
  - CB: {op_sel ? 8'b10110101 : 8'b10110100, imm[18:0], rd}.
  - I: {10'b1001000100, imm[11:0], rn, rd}.
  - B: {6'b000101, imm[25:0]}; rd and rn are ignored.
- Stage 2 (S2):
  - When s1_adv fires on an in-range entry, the encoded word is registered, out_valid goes to 1 and out_addr is set to {idx, 2'b00}.
  - Latency is 2 cycles from input handshake to out_valid with no stalls.
  - Throughput is 1 word per cycle.
- Out-of-range entry:
  - The entry is dropped at s1_adv and never reaches S2.
  - range_err pulses in the following cycle.
  - err_count increments and saturates at 255.
  - idx is unchanged.
  - The drop does not wait for S2 space.
- Output handshake:
  - A transfer occurs when out_valid and out_ready are both high; idx then increments, wrapping from 2^ADDR_W-1 to 0.
  - While out_valid is high and out_ready is low, instruction and out_addr hold stable.
  - The same-cycle S2 drain and S1 advance is legal and produces no bubble.
- idx: a word-index register, ADDR_W bits wide. out_addr for the next word uses the idx value after any same-cycle increment.
- clear:
  - Takes priority over all handshakes in that cycle.
  - Zeroes s1_valid, out_valid, idx and err_count.
  - in_ready reads 1 in the following cycle.
- Reset mid-operation: all in-flight entries are lost and no output is produced for them.

Test Plan:
- D, LDUR (fmt = 0, op_sel = 1), rd = 1, rn = 2, imm = -8 -> instruction 32'hF85F8041, out_addr 0, out_valid two cycles after the input handshake.
- CBNZ (fmt = 1, op_sel = 1), rd = 3, imm = -1 -> 32'hB5FFFFE3; then B (fmt = 3), imm = -2 -> 32'h17FFFFFE with out_addr 4.
- ADDI (fmt = 2), rd = 9, rn = 9, imm = 4095 -> 32'h913FFD29; the next entry, imm = 4096 -> no output, range_err pulses once, err_count = 1, the next word still gets out_addr 4.
- Backpressure: out_ready = 0 while pushing 3 entries -> in_ready drops after the 2nd is accepted and instruction/out_addr hold; release out_ready -> addresses 0, 4, 8 in order with no loss or duplication.
- Wrap and clear: ADDR_W = 2, issue 5 transfers -> out_addr sequence 0, 4, 8, 12, 0; assert clear with an entry in S2 -> out_valid = 0 and the next word gets out_addr 0.
- Reset mid-operation: drop reset_n while both stages are full -> all outputs return to reset values immediately; after release, encoding resumes at out_addr 0.
